// File: rtl/input_debouncer_pkg.sv
// -----------------------------------------------------------------------------
// input_debouncer_pkg
// Shared definitions for the board-input debouncer:
//   - db_state_e   : per-bit debounce FSM state (STABLE / PENDING)
//   - DEF_*        : default parameter values for input_debouncer
//   - min1_clog2() : counter width helper that never returns 0
// -----------------------------------------------------------------------------
package input_debouncer_pkg;

  // STABLE : synchronised input equals the accepted level.
  // PENDING: input differs from the level and the tick counter is running.
  typedef enum logic [0:0] {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } db_state_e;

  localparam int DEF_WIDTH        = 17;      // BTNC plus 16 switches
  localparam int DEF_TICK_DIV     = 100000;  // 1 ms sample tick at 100 MHz
  localparam int DEF_STABLE_TICKS = 10;      // ticks a new level must persist

  // Width of a counter holding 0..n-1; a single-value counter still needs 1 bit.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : input_debouncer_pkg

// File: rtl/input_debouncer_debounce_cell.sv
// -----------------------------------------------------------------------------
// debounce_cell
// One-bit debounce FSM with its stability counter and edge-pulse registers.
// The input is already synchronised; all state advances only on tick_i.
//
// Ports:
//   clk_i   in   system clock, rising edge
//   arst_i  in   asynchronous active-high reset
//   tick_i  in   one-cycle sample strobe from the shared prescaler
//   sync_i  in   synchronised raw input bit
//   level_o out  debounced level (registered)
//   rise_o  out  one-cycle pulse with the first cycle level_o shows 1
//   fall_o  out  one-cycle pulse with the first cycle level_o shows 0
//
// Build option: INPUT_DEBOUNCER_EDGE_EN defined builds the rise/fall pulse
// registers; otherwise rise_o/fall_o are tied to 0 and no flops exist for them.
// -----------------------------------------------------------------------------
module debounce_cell
  import input_debouncer_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic tick_i,
  input  logic sync_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  // Acceptance happens on the tick that would take count to STABLE_TICKS,
  // so the stored count never exceeds STABLE_TICKS-1.
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);
  localparam logic SINGLE_TICK = (STABLE_TICKS == 1) ? 1'b1 : 1'b0;

  db_state_e     state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          level_q, level_d;

  // Next-state logic of the debounce FSM, counter and accepted level.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    level_d = level_q;
    if (tick_i) begin
      case (state_q)
        STABLE: begin
          if (sync_i != level_q) begin
            if (SINGLE_TICK) begin
              level_d = sync_i;
              count_d = CNT_ZERO;
            end else begin
              count_d = CNT_ONE;
              state_d = PENDING;
            end
          end else begin
            count_d = CNT_ZERO;
          end
        end
        PENDING: begin
          if (sync_i == level_q) begin
            // Input went back before it was accepted: treat as a glitch.
            count_d = CNT_ZERO;
            state_d = STABLE;
          end else if (count_q == CNT_LAST) begin
            level_d = sync_i;
            count_d = CNT_ZERO;
            state_d = STABLE;
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end
        default: begin
          count_d = CNT_ZERO;
          state_d = STABLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State, counter and level registers.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= STABLE;
      count_q <= CNT_ZERO;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

`ifdef INPUT_DEBOUNCER_EDGE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Edge pulses are decoded from the level about to be loaded, so they
  // register on the same edge as the new level_o value.
  always_comb begin
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end

  // Edge pulse registers.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule : debounce_cell

// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
// Debounces WIDTH asynchronous board inputs. Each bit is synchronised by two
// flops, then sampled on a shared prescaler tick by its own debounce_cell.
//
// Ports:
//   clk_i    in   system clock, all logic on rising edge
//   arst_i   in   asynchronous active-high reset
//   raw_i    in   [WIDTH] asynchronous board pins (BTNC, SW)
//   level_o  out  [WIDTH] debounced, synchronised level
//   rise_o   out  [WIDTH] one-cycle pulse per accepted 0->1 transition
//   fall_o   out  [WIDTH] one-cycle pulse per accepted 1->0 transition
//
// Build option: INPUT_DEBOUNCER_EDGE_EN enables rise_o/fall_o; when undefined
// both are constant 0 and level_o behaves identically.
// -----------------------------------------------------------------------------
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  generate
    if ((WIDTH < 1) || (TICK_DIV < 1) || (STABLE_TICKS < 1)) begin : g_bad_param
      $error("input_debouncer: WIDTH, TICK_DIV and STABLE_TICKS must all be >= 1");
    end
  endgenerate

  localparam int PW = min1_clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tick_s;

  // Two-flop synchroniser for the asynchronous pins.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Prescaler next count; with TICK_DIV=1 PRE_LAST is 0 and tick is constant.
  always_comb begin
    tick_s = (pre_q == PRE_LAST);
    if (tick_s) begin
      pre_d = PW'(0);
    end else begin
      pre_d = pre_q + PW'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      pre_q <= PW'(0);
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    debounce_cell #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_cell (
      .clk_i  (clk_i),
      .arst_i (arst_i),
      .tick_i (tick_s),
      .sync_i (sync2_q[i]),
      .level_o(level_o[i]),
      .rise_o (rise_o[i]),
      .fall_o (fall_o[i])
    );
  end

endmodule : input_debouncer

// File: tb/tb_input_debouncer.sv
// -----------------------------------------------------------------------------
// tb_input_debouncer
// Directed bench for input_debouncer with WIDTH=4, TICK_DIV=4, STABLE_TICKS=3.
// With these values an accepted level appears 11..14 cycles after a raw step.
// Edge-pulse expectations follow INPUT_DEBOUNCER_EDGE_EN.
// -----------------------------------------------------------------------------
module tb_input_debouncer;

`ifdef INPUT_DEBOUNCER_EDGE_EN
  localparam int EDGE = 1;
`else
  localparam int EDGE = 0;
`endif

  logic       clk;
  logic       arst;
  logic [3:0] raw;
  logic [3:0] level;
  logic [3:0] rise;
  logic [3:0] fall;

  int n_cmp = 0;
  int n_err = 0;

  // Observation record, cleared by clear_obs.
  int         cyc;
  int         first_chg [4];
  int         chg_cnt   [4];
  int         rise_cnt  [4];
  int         fall_cnt  [4];
  int         rise_cyc  [4];
  int         fall_cyc  [4];
  int         both_cnt;
  logic [3:0] lvl_prev;

  input_debouncer #(
    .WIDTH       (4),
    .TICK_DIV    (4),
    .STABLE_TICKS(3)
  ) dut (
    .clk_i  (clk),
    .arst_i (arst),
    .raw_i  (raw),
    .level_o(level),
    .rise_o (rise),
    .fall_o (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int in_win(input int v);
    return (v >= 11 && v <= 14) ? 1 : 0;
  endfunction

  task automatic clear_obs();
    cyc      = 0;
    both_cnt = 0;
    for (int b = 0; b < 4; b++) begin
      first_chg[b] = -1;
      chg_cnt[b]   = 0;
      rise_cnt[b]  = 0;
      fall_cnt[b]  = 0;
      rise_cyc[b]  = -1;
      fall_cyc[b]  = -1;
    end
    lvl_prev = level;
  endtask

  // Advance ncyc clocks, sampling 1 time unit after each rising edge.
  task automatic observe(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      cyc++;
      for (int b = 0; b < 4; b++) begin
        if (level[b] != lvl_prev[b]) begin
          chg_cnt[b]++;
          if (first_chg[b] < 0) first_chg[b] = cyc;
        end
        if (rise[b]) begin
          rise_cnt[b]++;
          if (rise_cyc[b] < 0) rise_cyc[b] = cyc;
        end
        if (fall[b]) begin
          fall_cnt[b]++;
          if (fall_cyc[b] < 0) fall_cyc[b] = cyc;
        end
        if (rise[b] && fall[b]) both_cnt++;
      end
      lvl_prev = level;
    end
  endtask

  initial begin
    arst = 1'b1;
    raw  = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_level", int'(level), 0);
    check_eq("rst_rise",  int'(rise),  0);
    check_eq("rst_fall",  int'(fall),  0);
    arst = 1'b0;

    // Idle with all inputs low.
    clear_obs();
    observe(50);
    check_eq("idle_level_chg", chg_cnt[0] + chg_cnt[1] + chg_cnt[2] + chg_cnt[3], 0);
    check_eq("idle_rise", rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3], 0);
    check_eq("idle_fall", fall_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3], 0);

    // Clean 0->1 step on bit 0.
    raw = 4'b0001;
    clear_obs();
    observe(30);
    check_eq("b0_rise_lat_in_11_14", in_win(first_chg[0]), 1);
    check_eq("b0_level_after_rise", int'(level), 1);
    check_eq("b0_level_chg_cnt", chg_cnt[0], 1);
    check_eq("b0_rise_cnt", rise_cnt[0], EDGE);
    check_eq("b0_rise_cycle", rise_cyc[0], (EDGE == 1) ? first_chg[0] : -1);
    check_eq("b0_fall_cnt_on_rise", fall_cnt[0], 0);

    // Clean 1->0 step on bit 0.
    raw = 4'b0000;
    clear_obs();
    observe(30);
    check_eq("b0_fall_lat_in_11_14", in_win(first_chg[0]), 1);
    check_eq("b0_level_after_fall", int'(level), 0);
    check_eq("b0_fall_cnt", fall_cnt[0], EDGE);
    check_eq("b0_fall_cycle", fall_cyc[0], (EDGE == 1) ? first_chg[0] : -1);
    check_eq("b0_rise_cnt_on_fall", rise_cnt[0], 0);

    // Short 6-cycle pulse on bit 1 must be rejected.
    raw = 4'b0010;
    clear_obs();
    observe(6);
    raw = 4'b0000;
    observe(30);
    check_eq("b1_glitch_level_chg", chg_cnt[1], 0);
    check_eq("b1_glitch_rise", rise_cnt[1], 0);
    check_eq("b1_glitch_fall", fall_cnt[1], 0);

    // Bits 2 and 3 switch together.
    raw = 4'b1100;
    clear_obs();
    observe(30);
    check_eq("b32_level_high", int'(level), 12);
    check_eq("b32_same_change_cycle", first_chg[3], first_chg[2]);
    check_eq("b2_rise_cnt", rise_cnt[2], EDGE);
    check_eq("b3_rise_cnt", rise_cnt[3], EDGE);
    check_eq("b2_rise_cycle", rise_cyc[2], (EDGE == 1) ? first_chg[2] : -1);
    check_eq("b3_rise_cycle", rise_cyc[3], (EDGE == 1) ? first_chg[2] : -1);
    raw = 4'b0000;
    clear_obs();
    observe(30);
    check_eq("b32_level_low", int'(level), 0);
    check_eq("b2_fall_cnt", fall_cnt[2], EDGE);
    check_eq("b3_fall_cnt", fall_cnt[3], EDGE);
    check_eq("b2_fall_cycle", fall_cyc[2], (EDGE == 1) ? first_chg[2] : -1);
    check_eq("b3_fall_cycle", fall_cyc[3], (EDGE == 1) ? first_chg[2] : -1);
    check_eq("b32_both_pulses", both_cnt, 0);

    // Reset in the middle of a pending rise on bit 0.
    raw = 4'b0001;
    clear_obs();
    observe(8);
    check_eq("mid_pend_no_accept", chg_cnt[0], 0);
    arst = 1'b1;
    observe(2);
    check_eq("mid_rst_level", int'(level), 0);
    check_eq("mid_rst_rise", int'(rise), 0);
    arst = 1'b0;
    clear_obs();
    observe(30);
    check_eq("post_rst_lat_in_11_14", in_win(first_chg[0]), 1);
    check_eq("post_rst_rise_cnt", rise_cnt[0], EDGE);
    check_eq("post_rst_level", int'(level), 1);

    // Reset must clear an accepted level without waiting for a clock edge.
    #3;
    arst = 1'b1;
    #1;
    check_eq("async_clear_level", int'(level), 0);
    observe(2);
    arst = 1'b0;
    raw  = 4'b0000;
    clear_obs();
    observe(30);
    check_eq("after_async_no_change", chg_cnt[0], 0);
    check_eq("after_async_no_pulse", rise_cnt[0] + fall_cnt[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_input_debouncer
